// File: rtl/branch_resolution_unit_if.sv
// Signal bundle between the fetch/execute stages and the branch resolution unit.
// BRU_STATS_EN adds the statistics counter outputs.
interface branch_resolution_unit_if #(
  parameter int CNT_W = 32
);
  logic        en;
  logic        pred_valid;
  logic        pred_taken;
  logic [63:0] pred_pc;
  logic [63:0] pred_target;
  logic        pq_full;
  logic        res_valid;
  logic [1:0]  res_kind;
  logic        zero_in;
  logic        set_flags;
  logic [3:0]  alu_flags;
  logic        ActualBranch;
  logic        Flush;
  logic [63:0] redirect_pc;
  logic        pq_err;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("branch_resolution_unit_if: CNT_W must be at least 1");
  end

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] stat_resolved;
  logic [CNT_W-1:0] stat_mispred;

  modport master (
    output en, pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_kind, zero_in, set_flags, alu_flags,
    input  pq_full, ActualBranch, Flush, redirect_pc, pq_err,
    input  stat_resolved, stat_mispred
  );

  modport slave (
    input  en, pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_kind, zero_in, set_flags, alu_flags,
    output pq_full, ActualBranch, Flush, redirect_pc, pq_err,
    output stat_resolved, stat_mispred
  );
`else
  modport master (
    output en, pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_kind, zero_in, set_flags, alu_flags,
    input  pq_full, ActualBranch, Flush, redirect_pc, pq_err
  );

  modport slave (
    input  en, pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_kind, zero_in, set_flags, alu_flags,
    output pq_full, ActualBranch, Flush, redirect_pc, pq_err
  );
`endif
endinterface

// File: rtl/branch_resolution_unit.sv
// Execute-side branch resolution: in-order prediction queue, outcome evaluation, flush/redirect.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
module branch_resolution_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input logic                     clk,
  input logic                     reset,
  branch_resolution_unit_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("branch_resolution_unit: DEPTH must be a power of two >= 2 and CNT_W >= 1");
  end

  logic          q_taken  [DEPTH];
  logic [63:0]   q_pc     [DEPTH];
  logic [63:0]   q_target [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [3:0]    nzcv;
  logic          actual_q;
  logic          flush_q;
  logic          err_q;
  logic [63:0]   redirect_q;

  logic          full;
  logic          not_empty;
  logic          pop;
  logic          push;
  logic          actual;
  logic          mis;
  logic [3:0]    flags_eff;

  assign full = (count == FULL_CNT);

  // B.LT reads flags written by the instruction in EX this same cycle when present.
  always_comb begin
    not_empty = (count != '0);
    flags_eff = bus.set_flags ? bus.alu_flags : nzcv;
    actual    = 1'b0;
    case (bus.res_kind)
      2'b00:   actual = 1'b1;
      2'b01:   actual = bus.zero_in;
      2'b10:   actual = flags_eff[3] ^ flags_eff[0];
      default: actual = 1'b0;
    endcase
    pop  = bus.res_valid & not_empty;
    mis  = pop & (actual != q_taken[rd_ptr]);
    push = bus.pred_valid & ~full & ~mis;
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.en && push) begin
      q_taken[wr_ptr]  <= bus.pred_taken;
      q_pc[wr_ptr]     <= bus.pred_pc;
      q_target[wr_ptr] <= bus.pred_target;
    end
  end

  // A mispredict squashes everything younger than the head, including any wrong-path push.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      nzcv       <= 4'b0000;
      actual_q   <= 1'b0;
      flush_q    <= 1'b0;
      err_q      <= 1'b0;
      redirect_q <= '0;
    end else if (bus.en) begin
      if (bus.set_flags) nzcv <= bus.alu_flags;
      if (mis) begin
        count      <= '0;
        rd_ptr     <= rd_ptr + PW'(1);
        wr_ptr     <= rd_ptr + PW'(1);
        redirect_q <= actual ? q_target[rd_ptr] : q_pc[rd_ptr] + 64'd4;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
      if (bus.res_valid) actual_q <= actual;
      if (bus.res_valid && !not_empty) err_q <= 1'b1;
      flush_q <= mis;
    end
  end

  assign bus.pq_full      = full;
  assign bus.ActualBranch = actual_q;
  assign bus.Flush        = flush_q;
  assign bus.redirect_pc  = redirect_q;
  assign bus.pq_err       = err_q;

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] stat_res_q;
  logic [CNT_W-1:0] stat_mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else if (bus.en) begin
      if (pop && stat_res_q != '1) stat_res_q <= stat_res_q + CNT_W'(1);
      if (mis && stat_mis_q != '1) stat_mis_q <= stat_mis_q + CNT_W'(1);
    end
  end

  assign bus.stat_resolved = stat_res_q;
  assign bus.stat_mispred  = stat_mis_q;
`endif
endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Execute-side counterpart to the fetch-side branch predictor and hazard logic.
- Queues each fetched branch's prediction (PC, predicted direction, target) in program order.
- When the branch reaches EX, evaluates the real outcome from NZCV flags or the CBZ zero result.
- Drives ActualBranch, a one-cycle Flush/redirect on mispredict, and queue-full backpressure to IF.

Parameters:
- DEPTH, 4, prediction-queue entries (power of two, ≥2).
- CNT_W, 32, width of the statistics counters (only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- en  input  1  pipeline advance enable; when low, no state changes except reset
- pred_valid  input  1  IF pushes a branch prediction this cycle
- pred_taken  input  1  predicted direction (predictor ShouldTake, or 1 for B)
- pred_pc  input  64  PC of the branch instruction
- pred_target  input  64  taken-path target (PC + sign-extended offset)
- pq_full  output  1  queue full; IF must stall branch fetch
- res_valid  input  1  the branch at the queue head is in EX this cycle
- res_kind  input  2  00=B, 01=CBZ, 10=B.LT, 11=reserved
- zero_in  input  1  ALU zero for the CBZ operand
- set_flags  input  1  EX instruction writes NZCV this cycle
- alu_flags  input  4  {N,Z,C,V} from the ALU
- ActualBranch  output  1  resolved direction, registered
- Flush  output  1  mispredict pulse, registered
- redirect_pc  output  64  correct next PC, valid while Flush=1
- pq_err  output  1  sticky: res_valid seen with the queue empty

Behaviour:
- Reset:
  - Queue empty; read and write pointers = 0; count = 0.
  - NZCV = 0000.
  - Outputs ActualBranch, Flush, pq_err = 0; redirect_pc = 0.
  - Counters cleared.
  - Reset wins over every other input.
- Gating: all updates require en = 1. With en = 0, every register holds, including the Flush/ActualBranch registers.
- Flag register:
  - On en & set_flags, NZCV <= alu_flags.
  - B.LT evaluation uses alu_flags when set_flags = 1 in the same cycle (forwarded). Otherwise it uses the NZCV register.
- Queue:
  - Circular FIFO of {taken, pc, target}.
  - Push on en & pred_valid & !pq_full.
  - Pop on en & res_valid & (count != 0).
  - Push and pop in the same cycle: both happen; count is unchanged.
  - Push while full: dropped (IF is required to honour pq_full).
  - pq_full = (count == DEPTH), combinational from count.
  - Pointers wrap modulo DEPTH.
- Resolution (combinational from the head entry):
  - actual = 1 for B; zero_in for CBZ; N^V for B.LT; 0 for reserved.
  - mis = res_valid & (count != 0) & (actual != head.taken).
- Registered outputs (1-cycle latency, updated on en):
  - ActualBranch <= actual when res_valid, else holds its value.
  - Flush <= mis.
  - redirect_pc <= actual ? head.target : head.pc + 4, loaded only when mis.
- Mispredict recovery:
  - In the cycle mis = 1, the head pops and all younger entries are invalidated: count <= 0 and wr_ptr <= rd_ptr + 1.
  - A simultaneous push in that cycle is discarded, since it is wrong-path.
- Error: res_valid with count = 0 sets pq_err, with no pop and no Flush. pq_err clears only on reset.
- Reset asserted mid-operation: the queue empties and any Flush pending for the next cycle is cancelled (Flush = 0).

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined: adds outputs stat_resolved[CNT_W] and stat_mispred[CNT_W].
  - stat_resolved increments on every valid pop.
  - stat_mispred increments on every mis.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Correct prediction: reset; push {taken=1, pc=0x40, target=0x80}, kind=B; resolve next cycle -> ActualBranch=1, Flush=0, queue empty.
- CBZ mispredicted not-taken: push {taken=0, pc=0x100, target=0x200}; resolve with kind=CBZ, zero_in=1 -> one cycle later Flush=1, redirect_pc=0x200; Flush=0 the cycle after.
- B.LT predicted taken, actually not taken, with flag forwarding:
  - Stimulus: push {taken=1, pc=0x300}; resolve with set_flags=1, alu_flags=1001 (N=1, V=1) -> actual=0, Flush=1, redirect_pc=0x304.
  - Repeat using the registered NZCV=1000 -> actual=1, no Flush.
- Full and wrap: push 4 entries -> pq_full=1; 5th push ignored; pop 1 and push 1 in the same cycle, repeated 8 times -> FIFO order preserved across pointer wrap.
- Mispredict squash: 3 entries queued, head mispredicts while pred_valid=1 -> next cycle count=0, Flush=1; the next resolve with an empty queue sets pq_err=1.
- en and reset gating:
  - en=0 during a resolve -> no state change.
  - reset asserted in the mispredict cycle -> Flush stays 0 and queue is empty.
  - With BRU_STATS_EN: 3 resolves, 1 mispredict -> stat_resolved=3, stat_mispred=1.
